// File: rtl/conv_viterbi_decoder.sv
// Hard-decision Viterbi decoder for the K=7, rate-1/2 code (64 states).
// Parallel add-compare-select with register-exchange survivor paths.
module conv_viterbi_decoder #(
    parameter int DEPTH     = 32,
    parameter int PM_W      = 8,
    parameter int INIT_BIAS = 16
) (
    input  logic clkON,
    input  logic reset,
    input  logic in_A,
    input  logic in_B,
    input  logic inp_valid_i,
    output logic inp_ready_o,
    output logic out_bit,
    output logic out_valid_o,
    input  logic out_ready_i
);
    localparam int NS = 64;
    localparam int CW = $clog2(DEPTH);

    typedef enum logic {FILL, RUN} state_t;

    state_t           state, state_nx;
    logic [PM_W-1:0]  pm       [NS];
    logic [PM_W-1:0]  pm_raw   [NS];
    logic [PM_W-1:0]  pm_new   [NS];
    logic [DEPTH-1:0] path     [NS];
    logic [DEPTH-1:0] path_new [NS];
    logic [CW-1:0]    fcnt, fcnt_nx;
    logic             full_r, full_nx, bit_nx;
    logic             wr_en, accept;
    logic [PM_W-1:0]  pm_min;
    logic [5:0]       best;
    logic             norm;

    function automatic logic [1:0] branch_metric(
        input logic [5:0] p,
        input logic       b,
        input logic       ra,
        input logic       rb
    );
        logic ea, eb;
        ea = b ^ p[1] ^ p[2] ^ p[4] ^ p[5];
        eb = b ^ p[0] ^ p[1] ^ p[2] ^ p[5];
        return {1'b0, ra ^ ea} + {1'b0, rb ^ eb};
    endfunction

    for (genvar n = 0; n < NS; n++) begin : g_acs
        localparam logic [5:0] P0 = {1'b0, 5'(n >> 1)};
        localparam logic [5:0] P1 = {1'b1, 5'(n >> 1)};
        localparam logic       B  = 1'(n % 2);
        logic [PM_W:0] c0, c1;
        logic          sel;
        assign c0  = {1'b0, pm[P0]}
                   + (PM_W+1)'(branch_metric(P0, B, in_A, in_B));
        assign c1  = {1'b0, pm[P1]}
                   + (PM_W+1)'(branch_metric(P1, B, in_A, in_B));
        // Ties resolve to the x=0 predecessor.
        assign sel = c1 < c0;
        assign pm_raw[n]   = sel ? c1[PM_W-1:0] : c0[PM_W-1:0];
        assign path_new[n] = {sel ? path[P1][DEPTH-2:0]
                                  : path[P0][DEPTH-2:0], B};
        assign pm_new[n]   = {pm_raw[n][PM_W-1] & ~norm,
                              pm_raw[n][PM_W-2:0]};
    end

    // Lowest index wins ties because only strictly smaller replaces.
    always_comb begin
        pm_min = pm_raw[0];
        best   = '0;
        for (int n = 1; n < NS; n++) begin
            if (pm_raw[n] < pm_min) begin
                pm_min = pm_raw[n];
                best   = 6'(n);
            end
        end
    end

    assign norm        = pm_min[PM_W-1];
    assign wr_en       = ~full_r | out_ready_i;
    assign accept      = wr_en & inp_valid_i;
    assign inp_ready_o = wr_en;
    assign out_valid_o = full_r;

    always_comb begin
        state_nx = state;
        fcnt_nx  = fcnt;
        full_nx  = full_r;
        bit_nx   = out_bit;
        if (wr_en && !inp_valid_i) full_nx = 1'b0;
        if (accept) begin
            unique case (state)
                FILL: begin
                    fcnt_nx = fcnt + CW'(1);
                    full_nx = 1'b0;
                    if (fcnt == CW'(DEPTH - 2)) state_nx = RUN;
                end
                RUN: begin
                    full_nx = 1'b1;
                    bit_nx  = path_new[best][DEPTH-1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clkON) begin
        if (reset) begin
            state   <= FILL;
            fcnt    <= '0;
            full_r  <= 1'b0;
            out_bit <= 1'b0;
            for (int n = 0; n < NS; n++) begin
                pm[n]   <= (n == 0) ? '0 : PM_W'(INIT_BIAS);
                path[n] <= '0;
            end
        end else begin
            state   <= state_nx;
            fcnt    <= fcnt_nx;
            full_r  <= full_nx;
            out_bit <= bit_nx;
            if (accept) begin
                pm   <= pm_new;
                path <= path_new;
            end
        end
    end
endmodule

// File: tb/tb_conv_viterbi_decoder.sv
// Bench for conv_viterbi_decoder: vector table, backpressure sequence
// and random noisy traffic against a trellis-search reference model.
module tb_conv_viterbi_decoder;
    localparam int DEPTH = 32;
    localparam int PM_W  = 8;
    localparam int BIAS  = 16;

    logic clkON = 1'b0;
    logic reset = 1'b1;
    logic in_A = 1'b0, in_B = 1'b0;
    logic inp_valid_i = 1'b0, out_ready_i = 1'b0;
    logic inp_ready_o, out_bit, out_valid_o;

    conv_viterbi_decoder #(
        .DEPTH(DEPTH), .PM_W(PM_W), .INIT_BIAS(BIAS)
    ) dut (
        .clkON(clkON), .reset(reset),
        .in_A(in_A), .in_B(in_B),
        .inp_valid_i(inp_valid_i), .inp_ready_o(inp_ready_o),
        .out_bit(out_bit), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i)
    );

    always #5 clkON = ~clkON;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          pm_m   [64];
    logic [63:0] path_m [64];
    int          acc_cnt;
    bit          full_m;
    bit          exp_q [$];
    int          norm_cnt = 0;
    logic [63:0] got_bits;
    int          got_n;
    int          first_acc;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Encoder: register s holds past inputs, bit0 = most recent.
    function automatic logic [1:0] enc(input logic [5:0] s, input logic u);
        enc[1] = u ^ s[1] ^ s[2] ^ s[4] ^ s[5];
        enc[0] = u ^ s[0] ^ s[1] ^ s[2] ^ s[5];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 64; k++) begin
            pm_m[k]   = (k == 0) ? 0 : BIAS;
            path_m[k] = '0;
        end
        acc_cnt = 0;
        full_m  = 0;
        exp_q.delete();
        got_n    = 0;
        got_bits = '0;
        first_acc = -1;
    endtask

    // Forward trellis search: extend every state by both inputs.
    task automatic model_accept(input logic a, input logic bb);
        int          np   [64];
        logic [63:0] npth [64];
        bit          seen [64];
        int p, n, c, mn, bst;
        logic [1:0] e;
        for (int k = 0; k < 64; k++) seen[k] = 0;
        for (int x = 0; x < 2; x++)
            for (int lo = 0; lo < 32; lo++)
                for (int u = 0; u < 2; u++) begin
                    p = x * 32 + lo;
                    n = (p * 2) % 64 + u;
                    e = enc(6'(p), 1'(u));
                    c = pm_m[p] + int'(e[1] ^ a) + int'(e[0] ^ bb);
                    if (!seen[n] || c < np[n]) begin
                        np[n]   = c;
                        npth[n] = (path_m[p] << 1) | 64'(u);
                        seen[n] = 1;
                    end
                end
        mn = np[0];
        bst = 0;
        for (int k = 1; k < 64; k++)
            if (np[k] < mn) begin mn = np[k]; bst = k; end
        if (mn >= 2 ** (PM_W - 1)) begin
            for (int k = 0; k < 64; k++) np[k] -= 2 ** (PM_W - 1);
            norm_cnt++;
        end
        for (int k = 0; k < 64; k++) begin
            pm_m[k]   = np[k];
            path_m[k] = npth[k];
        end
        acc_cnt++;
        if (acc_cnt >= DEPTH) begin
            exp_q.push_back(npth[bst][DEPTH-1]);
            full_m = 1;
        end else begin
            full_m = 0;
        end
    endtask

    task automatic cyc(input logic a, input logic bb, input logic v, input logic r);
        bit wr;
        in_A = a; in_B = bb; inp_valid_i = v; out_ready_i = r;
        @(negedge clkON);
        wr = !full_m || r;
        check("ready", inp_ready_o, wr);
        check("valid", out_valid_o, full_m);
        if (full_m && exp_q.size() > 0) check("out_bit", out_bit, exp_q[0]);
        if (full_m && r) begin
            if (got_n == 0) first_acc = acc_cnt;
            if (got_n < 64) got_bits[got_n] = out_bit;
            got_n++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (wr) begin
            if (v) model_accept(a, bb);
            else full_m = 0;
        end
        @(posedge clkON);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; inp_valid_i = 1'b0; out_ready_i = 1'b0;
        repeat (n) @(posedge clkON);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic cmp_pm(input string nm);
        int bad;
        bad = 0;
        for (int k = 0; k < 64; k++)
            if (int'(dut.pm[k]) != pm_m[k]) bad++;
        check(nm, bad, 0);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  pat;
        int          flip_idx;
        logic [1:0]  flip;
        int          nsym;
        int          exp_n;
        logic [63:0] exp_bits;
        int          exp_first;
    } vec_t;

    vec_t        tbl [5];
    logic [5:0]  s;
    logic [1:0]  sy;
    logic        u, v, r, held;
    logic [63:0] mask;
    int          acc_before, i;

    initial begin
        tbl[0] = '{"zeros",       8'h00, -1, 2'b00, 40, 9, 64'h0, 32};
        tbl[1] = '{"impulse",     8'h01, -1, 2'b00, 40, 9, 64'h1, 32};
        tbl[2] = '{"impulse_err", 8'h01,  1, 2'b01, 40, 9, 64'h1, 32};
        tbl[3] = '{"double",      8'h03, -1, 2'b00, 42, 11, 64'h3, 32};
        tbl[4] = '{"zeros_err",   8'h00,  5, 2'b10, 40, 9, 64'h0, 32};

        // Reset state
        do_reset(2);
        @(negedge clkON);
        check("rst.valid", out_valid_o, 0);
        check("rst.bit", out_bit, 0);
        check("rst.ready", inp_ready_o, 1);
        check("rst.pm0", dut.pm[0], 0);
        check("rst.pm5", dut.pm[5], 16);
        @(posedge clkON);
        #1;

        foreach (tbl[t]) begin
            do_reset(1);
            s = '0;
            for (int k = 0; k < tbl[t].nsym; k++) begin
                u  = (k < 8) ? tbl[t].pat[k] : 1'b0;
                sy = enc(s, u);
                s  = {s[4:0], u};
                if (k == tbl[t].flip_idx) sy = sy ^ tbl[t].flip;
                cyc(sy[1], sy[0], 1'b1, 1'b1);
            end
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            mask = (64'd1 << tbl[t].exp_n) - 64'd1;
            check({tbl[t].name, ".count"}, got_n, tbl[t].exp_n);
            check({tbl[t].name, ".bits"}, got_bits & mask, tbl[t].exp_bits);
            check({tbl[t].name, ".first"}, first_acc, tbl[t].exp_first);
        end

        // Backpressure in RUN
        do_reset(1);
        s = '0;
        for (int k = 0; k < 36; k++) begin
            u = 1'($urandom);
            sy = enc(s, u);
            s = {s[4:0], u};
            cyc(sy[1], sy[0], 1'b1, 1'b1);
        end
        held = out_bit;
        u = 1'($urandom);
        sy = enc(s, u);
        for (int k = 0; k < 5; k++) begin
            cyc(sy[1], sy[0], 1'b1, 1'b0);
            check("bp.ready", inp_ready_o, 0);
            check("bp.hold", out_bit, held);
        end
        s = {s[4:0], u};
        cyc(sy[1], sy[0], 1'b1, 1'b1);
        for (int k = 0; k < 40; k++) begin
            u = 1'($urandom);
            sy = enc(s, u);
            s = {s[4:0], u};
            cyc(sy[1], sy[0], 1'b1, 1'b1);
        end
        cmp_pm("bp.pm");

        // Mid-stream reset then random noisy traffic
        do_reset(1);
        s = '0;
        for (int k = 0; k < 20; k++)
            cyc(1'($urandom), 1'($urandom), 1'b1, 1'b1);
        do_reset(1);
        s = '0;
        i = 0;
        while ((i < 200 || norm_cnt == 0) && i < 4000) begin
            v = ($urandom_range(7) != 0);
            r = ($urandom_range(3) != 0);
            u = 1'($urandom);
            sy = enc(s, u);
            if ($urandom_range(3) == 0) sy[0] = ~sy[0];
            if ($urandom_range(3) == 0) sy[1] = ~sy[1];
            acc_before = acc_cnt;
            cyc(sy[1], sy[0], v, r);
            if (acc_cnt != acc_before) s = {s[4:0], u};
            if (i % 50 == 0) cmp_pm("rnd.pm");
            i++;
        end
        cmp_pm("rnd.pm_final");
        check("rnd.first", first_acc, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
